frodo_agu_seq: RTL
==================

# frodo_agu_seq

Loop sequencer that drives the four-port address generator (ports A/B/C/D) of the Frodo matrix datapath. It accepts one two-level loop command (outer count × inner count) through a start/busy/done handshake. It then emits the per-cycle `clr_en`/`add_en`/`stride` control pulses that step the address generator through a matrix pass. It sits between the top-level control FSM and the address generator, and provides a `step_valid` tag for the arithmetic datapath.

## Interface
Parameters:
- `CNT_WIDTH`, 12: width of the outer and inner loop counts and counters.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  command strobe; sampled only while `busy`=0.
- `abort`  in  1  synchronous abort; returns to IDLE without `done`.
- `stall`  in  1  freezes the sequencer for this cycle.
- `cfg_outer`  in  CNT_WIDTH  outer iteration count O.
- `cfg_inner`  in  CNT_WIDTH  inner iteration count N.
- `cfg_inner_mask`  in  4  ports advanced on every inner step.
- `cfg_outer_mask`  in  4  ports advanced at each inner-loop wrap.
- `cfg_rewind_mask`  in  4  ports reloaded to their start address at each wrap.
- `cfg_stride`  in  4  per-port stride select, passed through.
- `clr_en`  out  4  to address generator; bit i reloads port i.
- `add_en`  out  4  to address generator; bit i increments port i.
- `stride`  out  4  to address generator.
- `step_valid`  out  1  high on every non-stalled inner step.
- `last_inner`  out  1  high on the step_valid cycle with k = N-1.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, INIT, RUN, WRAP, DONE. Inner counter k and outer counter o, both CNT_WIDTH wide.
- **IDLE**: on `start`, latch all `cfg_*` and clear k and o; go to INIT.
- **INIT**:
  - Drive `clr_en`=4'b1111.
  - If O=0 or N=0, go to DONE. Otherwise go to RUN.
- **RUN**:
  - Drive `add_en`=inner_mask and `step_valid`=1.
  - If k=N-1, set `last_inner`=1 and go to WRAP. Otherwise k++.
- **WRAP**:
  - Drive `add_en`=outer_mask and `clr_en`=rewind_mask. Where the masks overlap, clr wins inside the address generator; the sequencer drives both bits unchanged.
  - If o=O-1, go to DONE. Otherwise o++, k=0, go to RUN.
- **DONE**: `done`=1; go to IDLE.
- `stall`=1: `clr_en`, `add_en`, `step_valid`, `last_inner` and `done` are forced to 0. State and counters hold.
- `abort`=1 in any non-IDLE state: next state is IDLE and all outputs are 0 in this cycle. `abort` has priority over `stall`.
- `start` while `busy`=1 is ignored, including in the DONE cycle.
- `stride` = latched cfg_stride while busy, 0 in IDLE.
- Counters never wrap. Compares are exact against the latched counts. O and N up to 2^CNT_WIDTH-1 are legal.
- Reset mid-operation: immediate return to IDLE.

## Timing
- Moore style: outputs are decoded from registered state and counters, with only the `stall`/`abort` gating combinational.
- Reset value of every output: 0.
- With `start` sampled at edge 0:
  - INIT occupies cycle 1.
  - The first RUN cycle is cycle 2.
  - Total busy cycles without stalls = 1 + O·(N+1) + 1.
- Each stall cycle extends the sequence by exactly one cycle.
- The earliest next `start` is accepted in the first IDLE cycle after `done`.

## Configuration
- `AGU_SEQ_PERF_EN` defined: adds outputs `perf_cycles` [31:0] and `perf_stalls` [31:0].
  - Both clear when `start` is accepted.
  - `perf_cycles` counts every busy cycle; `perf_stalls` counts busy cycles with `stall`=1.
  - Both saturate at all-ones and hold their value after `done` or `abort`.
- Not defined: these ports and counters do not exist.

## Structure
- Package `frodo_agu_pkg` holds:
  - the state enum;
  - port index constants PORT_A=0, PORT_B=1, PORT_C=2, PORT_D=3;
  - the default CNT_WIDTH.
- One sub-module, `agu_loop_cnt`: a counter with clear, enable and terminal-count (`== limit-1`) output, instantiated for k and o.

## Test plan
- O=2, N=3, inner=0011, outer=0100, rewind=0001 → cycle 1 clr=1111; cycles 2–4 add=0011; cycle 5 add=0100 clr=0001; cycles 6–8 add=0011; cycle 9 add=0100 clr=0001; cycle 10 done=1; busy high cycles 1–10.
- Same command with `stall` high in cycles 3 and 6 → add=0 in those cycles, sequence shifted, done at cycle 12, step_valid count = 6.
- O=0 or N=0 → INIT clr=1111 in cycle 1, done in cycle 2, no add_en pulse.
- `start` asserted during RUN and in the DONE cycle → ignored; a single done; latched counts unchanged.
- `abort` in cycle 4 of O=2, N=3 → all outputs 0, IDLE in cycle 5, no done; a new start is then accepted normally.
- `rstn` low during WRAP → all outputs 0 immediately; with PERF enabled, perf_cycles=10 and perf_stalls=0 after the first scenario.

Source files
------------

// File: rtl/frodo_agu_pkg.sv
// Shared definitions for the Frodo address-generator loop sequencer:
// sequencer state encoding, address-generator port indices and the
// default loop-counter width.
package frodo_agu_pkg;

  localparam int CNT_WIDTH_DEF = 12;
  localparam int NUM_PORTS     = 4;

  localparam int PORT_A = 0;
  localparam int PORT_B = 1;
  localparam int PORT_C = 2;
  localparam int PORT_D = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_RUN  = 3'd2,
    ST_WRAP = 3'd3,
    ST_DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/frodo_agu_seq_loop_cnt.sv
// Loop counter with synchronous clear, count enable and a terminal-count
// flag that is high when the count equals limit-1. Used for both the
// inner (k) and outer (o) loop indices of the sequencer.
module agu_loop_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] ONE = W'(1);

  // Count register: clear has priority over increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + ONE;
    end
  end

  // A limit of zero never reaches this compare: the sequencer leaves
  // for DONE straight from INIT in that case.
  assign tc = (count == (limit - ONE));

endmodule

// File: rtl/frodo_agu_seq.sv
// Two-level loop sequencer for the four-port Frodo address generator.
// Accepts one outer x inner loop command via start/busy/done and emits
// per-cycle clr_en/add_en/stride pulses plus a step_valid tag.
// Optional build macro AGU_SEQ_PERF_EN adds perf_cycles/perf_stalls.
module frodo_agu_seq
  import frodo_agu_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 stall,
  input  logic [CNT_WIDTH-1:0] cfg_outer,
  input  logic [CNT_WIDTH-1:0] cfg_inner,
  input  logic [3:0]           cfg_inner_mask,
  input  logic [3:0]           cfg_outer_mask,
  input  logic [3:0]           cfg_rewind_mask,
  input  logic [3:0]           cfg_stride,
  output logic [3:0]           clr_en,
  output logic [3:0]           add_en,
  output logic [3:0]           stride,
  output logic                 step_valid,
  output logic                 last_inner,
  output logic                 busy,
  output logic                 done
`ifdef AGU_SEQ_PERF_EN
  ,
  output logic [31:0]          perf_cycles,
  output logic [31:0]          perf_stalls
`endif
);

  seq_state_t state_reg, state_next;

  logic [CNT_WIDTH-1:0] outer_reg, inner_reg;
  logic [3:0]           inner_mask_reg, outer_mask_reg, rewind_mask_reg, stride_reg;

  logic [CNT_WIDTH-1:0] k_count, o_count;
  logic                 k_tc, o_tc;

  logic in_idle, start_acc, active, wrap_adv, zero_cnt;

  assign in_idle   = (state_reg == ST_IDLE);
  assign start_acc = in_idle && start;
  // abort only matters outside IDLE, where every output is 0 anyway
  assign active    = !stall && !abort;
  assign wrap_adv  = (state_reg == ST_WRAP) && active && !o_tc;
  assign zero_cnt  = (outer_reg == '0) || (inner_reg == '0);

  // Command latch: captured once per accepted start, held for the pass.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outer_reg       <= '0;
      inner_reg       <= '0;
      inner_mask_reg  <= '0;
      outer_mask_reg  <= '0;
      rewind_mask_reg <= '0;
      stride_reg      <= '0;
    end else if (start_acc) begin
      outer_reg       <= cfg_outer;
      inner_reg       <= cfg_inner;
      inner_mask_reg  <= cfg_inner_mask;
      outer_mask_reg  <= cfg_outer_mask;
      rewind_mask_reg <= cfg_rewind_mask;
      stride_reg      <= cfg_stride;
    end
  end

  // Inner index k: advances on non-final RUN steps, restarts at each wrap.
  agu_loop_cnt #(.W(CNT_WIDTH)) u_k_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (start_acc || wrap_adv),
    .en    ((state_reg == ST_RUN) && active && !k_tc),
    .limit (inner_reg),
    .count (k_count),
    .tc    (k_tc)
  );

  // Outer index o: advances on every wrap that is not the final one.
  agu_loop_cnt #(.W(CNT_WIDTH)) u_o_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (start_acc),
    .en    (wrap_adv),
    .limit (outer_reg),
    .count (o_count),
    .tc    (o_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: abort beats stall, stall freezes, otherwise walk the loops.
  always_comb begin
    state_next = state_reg;
    if (!in_idle && abort) begin
      state_next = ST_IDLE;
    end else if (!in_idle && stall) begin
      state_next = state_reg;
    end else begin
      case (state_reg)
        ST_IDLE: if (start) state_next = ST_INIT;
        ST_INIT: state_next = zero_cnt ? ST_DONE : ST_RUN;
        ST_RUN:  if (k_tc) state_next = ST_WRAP;
        ST_WRAP: state_next = o_tc ? ST_DONE : ST_RUN;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Output decode from registered state; stall/abort gate combinationally.
  always_comb begin
    clr_en     = 4'b0000;
    add_en     = 4'b0000;
    step_valid = 1'b0;
    last_inner = 1'b0;
    done       = 1'b0;
    busy       = !in_idle && !abort;
    stride     = (!in_idle && !abort) ? stride_reg : 4'b0000;
    if (active) begin
      case (state_reg)
        ST_INIT: clr_en = 4'b1111;
        ST_RUN: begin
          add_en     = inner_mask_reg;
          step_valid = 1'b1;
          last_inner = k_tc;
        end
        ST_WRAP: begin
          // overlapping bits are resolved (clr wins) in the address generator
          add_en = outer_mask_reg;
          clr_en = rewind_mask_reg;
        end
        ST_DONE: done = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef AGU_SEQ_PERF_EN
  // Saturating activity counters, cleared by each accepted command.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (start_acc) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (!in_idle) begin
      if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (stall && (perf_stalls != '1)) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
